// File: rtl/note_select.sv
// PS/2 set-2 keyboard front end: parses make/break codes, tracks up to two held
// note keys, and emits rate-limited note-change pulses to the physics block.
module note_select #(
  parameter int unsigned MIN_GAP = 65000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [4:0] freq_id1,
  output logic [4:0] freq_id2,
  output logic       new_f,
  output logic [1:0] key_count
);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } parse_t;

  localparam logic [4:0]  NONE     = 5'd31;
  localparam logic [7:0]  CODE_BRK = 8'hF0;
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [16:0] GAP_LOAD = 17'(MIN_GAP - 1);

  function automatic logic [4:0] map_code(input logic [7:0] code);
    case (code)
      8'h1A: map_code = 5'd0;
      8'h1B: map_code = 5'd1;
      8'h22: map_code = 5'd2;
      8'h23: map_code = 5'd3;
      8'h21: map_code = 5'd4;
      8'h2A: map_code = 5'd5;
      8'h34: map_code = 5'd6;
      8'h32: map_code = 5'd7;
      8'h33: map_code = 5'd8;
      8'h31: map_code = 5'd9;
      8'h3B: map_code = 5'd10;
      8'h3A: map_code = 5'd11;
      8'h41: map_code = 5'd12;
      8'h15: map_code = 5'd13;
      8'h1E: map_code = 5'd14;
      8'h1D: map_code = 5'd15;
      8'h26: map_code = 5'd16;
      8'h24: map_code = 5'd17;
      8'h2D: map_code = 5'd18;
      8'h2E: map_code = 5'd19;
      8'h2C: map_code = 5'd20;
      8'h36: map_code = 5'd21;
      8'h35: map_code = 5'd22;
      8'h3D: map_code = 5'd23;
      8'h3C: map_code = 5'd24;
      default: map_code = NONE;
    endcase
  endfunction

  parse_t      state, state_nx;
  logic [4:0]  slot1, slot2, slot1_nx, slot2_nx;
  logic [4:0]  key_id;
  logic        make_ev, brk_ev;
  logic        pending;
  logic [16:0] gap_cnt;
  logic        emit_edge, slot_change, pulse;

  assign key_id = map_code(scan_code);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == CODE_BRK)      state_nx = BRK;
          else if (scan_code == CODE_EXT) state_nx = EXT;
          else                            make_ev  = (key_id != NONE);
        end
        BRK: begin
          brk_ev   = (key_id != NONE);
          state_nx = IDLE;
        end
        EXT:     state_nx = (scan_code == CODE_BRK) ? EXT_BRK : IDLE;
        EXT_BRK: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Slot bookkeeping keeps slot1 filled first and compacts slot2 down on release.
  always_comb begin
    slot1_nx = slot1;
    slot2_nx = slot2;
    if (make_ev && key_id != slot1 && key_id != slot2) begin
      if (slot1 == NONE)      slot1_nx = key_id;
      else if (slot2 == NONE) slot2_nx = key_id;
    end
    if (brk_ev) begin
      if (key_id == slot1) begin
        slot1_nx = slot2;
        slot2_nx = NONE;
      end else if (key_id == slot2) begin
        slot2_nx = NONE;
      end
    end
  end

  assign slot_change = (slot1_nx != slot1) || (slot2_nx != slot2);
  // The !new_f term only matters for MIN_GAP=1, where it keeps pulses non-adjacent.
  assign emit_edge   = pending && (gap_cnt == 17'd0) && !new_f;
  assign pulse       = emit_edge && ((slot1 != freq_id1) || (slot2 != freq_id2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      slot1     <= NONE;
      slot2     <= NONE;
      key_count <= 2'd0;
      pending   <= 1'b0;
      gap_cnt   <= 17'd0;
      freq_id1  <= NONE;
      freq_id2  <= NONE;
      new_f     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nx;
      slot1     <= slot1_nx;
      slot2     <= slot2_nx;
      key_count <= 2'((slot1_nx != NONE) + (slot2_nx != NONE));
      new_f     <= pulse;
      if (pulse) begin
        freq_id1 <= slot1;
        freq_id2 <= slot2;
      end
      // A slot change on the emit edge re-arms pending so it goes out after the gap.
      if (slot_change)    pending <= 1'b1;
      else if (emit_edge) pending <= 1'b0;
      if (pulse)                   gap_cnt <= GAP_LOAD;
      else if (gap_cnt != 17'd0)   gap_cnt <= gap_cnt - 17'd1;
    end
  end

endmodule

// File: tb/tb_note_select.sv
// Directed bench for note_select: parser, slot policy, gap coalescing and reset.
module tb_note_select;

  localparam int unsigned GAP = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [4:0] freq_id1, freq_id2;
  logic       new_f;
  logic [1:0] key_count;

  note_select #(.MIN_GAP(GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .freq_id1   (freq_id1),
    .freq_id2   (freq_id2),
    .new_f      (new_f),
    .key_count  (key_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int f1;
    int f2;
  } pulse_t;

  pulse_t pulses[$];
  int     stray = 0;
  int     dbl   = 0;
  logic   prev_new_f = 1'b0;
  logic [4:0] prev_f1 = 5'd31, prev_f2 = 5'd31;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse recorder plus output-stability watch (freq changes only with new_f).
  always @(negedge clock) begin
    if (!reset) begin
      if (new_f) begin
        pulses.push_back('{cyc, int'(freq_id1), int'(freq_id2)});
        if (prev_new_f) dbl++;
      end else if (freq_id1 != prev_f1 || freq_id2 != prev_f2) begin
        stray++;
      end
    end
    prev_new_f = new_f;
    prev_f1    = freq_id1;
    prev_f2    = freq_id2;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] code);
    scan_code  = code;
    scan_valid = 1'b1;
    @(negedge clock);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    idle(3);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  // Waits (bounded) for one new pulse and checks its payload and key_count.
  task automatic expect_pulse(input string tag, input int f1, input int f2, input int kc);
    int start = pulses.size();
    for (int i = 0; i < 4 * GAP && pulses.size() == start; i++) @(negedge clock);
    check({tag, "_seen"}, int'(pulses.size() > start), 1);
    if (pulses.size() > start) begin
      check({tag, "_f1"}, pulses[start].f1, f1);
      check({tag, "_f2"}, pulses[start].f2, f2);
    end
    check({tag, "_kc"}, int'(key_count), kc);
  endtask

  initial begin
    int n0;
    idle(2);
    check("rst_f1", int'(freq_id1), 31);
    check("rst_f2", int'(freq_id2), 31);
    check("rst_newf", int'(new_f), 0);
    check("rst_kc", int'(key_count), 0);
    #2 reset = 1'b0;
    idle(2);

    // Single press: slots move one cycle after the strobe, pulse one cycle later.
    send(8'h1A);
    check("lat_kc_n1", int'(key_count), 1);
    check("lat_newf_n1", int'(new_f), 0);
    @(negedge clock);
    check("lat_newf_n2", int'(new_f), 1);
    check("lat_f1", int'(freq_id1), 0);
    check("lat_f2", int'(freq_id2), 31);
    @(negedge clock);
    check("lat_newf_n3", int'(new_f), 0);
    idle(20);

    // Second slot fill, then release of slot1 compacts slot2 down.
    send(8'h3C);
    expect_pulse("two", 0, 24, 2);
    idle(20);
    send(8'hF0); send(8'h1A);
    expect_pulse("compact", 24, 31, 1);

    // Third key with both slots full is dropped.
    do_reset();
    send(8'h1A);
    expect_pulse("fill1", 0, 31, 1);
    idle(20);
    send(8'h22);
    expect_pulse("fill2", 0, 2, 2);
    idle(20);
    n0 = pulses.size();
    send(8'h21);
    idle(3 * GAP);
    check("full_nopulse", pulses.size() - n0, 0);
    check("full_kc", int'(key_count), 2);
    send(8'hF0); send(8'h22);
    expect_pulse("rel_slot2", 0, 31, 1);

    // Typematic repeats, extended keys and non-key bytes produce nothing.
    do_reset();
    n0 = pulses.size();
    repeat (5) send(8'h1A);
    idle(3 * GAP);
    check("typematic_pulses", pulses.size() - n0, 1);
    check("typematic_f1", int'(freq_id1), 0);
    n0 = pulses.size();
    send(8'hE0); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h1A);
    send(8'hAA); send(8'hFA);
    idle(3 * GAP);
    check("ext_nopulse", pulses.size() - n0, 0);
    check("ext_kc", int'(key_count), 1);
    check("ext_f1", int'(freq_id1), 0);

    // Change inside the gap is deferred to exactly MIN_GAP after the first pulse.
    do_reset();
    n0 = pulses.size();
    send(8'h1A);
    idle(2);
    send(8'h22);
    idle(3 * GAP);
    check("gap_pulses", pulses.size() - n0, 2);
    if (pulses.size() - n0 == 2) begin
      check("gap_spacing", pulses[n0+1].cyc - pulses[n0].cyc, GAP);
      check("gap_f1", pulses[n0+1].f1, 0);
      check("gap_f2", pulses[n0+1].f2, 2);
    end

    // Release and re-press within the gap leaves outputs equal: no second pulse.
    do_reset();
    n0 = pulses.size();
    send(8'h1A);
    idle(2);
    send(8'hF0); send(8'h1A);
    check("coal_kc_mid", int'(key_count), 0);
    check("coal_f1_mid", int'(freq_id1), 0);
    send(8'h1A);
    idle(3 * GAP);
    check("coal_pulses", pulses.size() - n0, 1);
    check("coal_kc", int'(key_count), 1);

    // Reset after F0 discards the prefix; 1A then parses as a make.
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1A);
    expect_pulse("rst_brk", 0, 31, 1);

    // Asynchronous reset mid-gap with pending: immediate clear and no pulse.
    send(8'h22);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_f1", int'(freq_id1), 31);
    check("arst_f2", int'(freq_id2), 31);
    check("arst_kc", int'(key_count), 0);
    check("arst_newf", int'(new_f), 0);
    idle(2);
    #2 reset = 1'b0;
    n0 = pulses.size();
    idle(3 * GAP);
    check("arst_nopulse", pulses.size() - n0, 0);

    check("no_stray_change", stray, 0);
    check("no_double_pulse", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
